// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default constants for the data-memory arbiter.
// Imported by the winner-select helper and by the arbiter top.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } arb_owner_t;

  localparam int unsigned WAIT_CYCLES_DEF = 1;
  localparam int unsigned MAX_BURST_DEF   = 4;
  // Wide enough for both the wait counter and the burst counter (max 15).
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/dmem_arbiter_pick.sv
// Combinational two-way winner select: locked DMA burst first, then a single
// requester, then round-robin against the last owner.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,       // [0] = CPU, [1] = DMA
  input  arb_owner_t last_i,
  input  logic       lock_i,
  input  logic       burst_ok_i,
  output logic       valid_o,
  output arb_owner_t winner_o,
  output logic       locked_o
);

  always_comb begin
    // NOTE: every output gets a default before the branches, so no latch is inferred.
    winner_o = OWN_CPU;
    valid_o  = |req_i;
    locked_o = (last_i == OWN_DMA) && lock_i && req_i[1] && (burst_ok_i || !req_i[0]);

    if (locked_o) begin
      winner_o = OWN_DMA;
    end else if (req_i == 2'b10) begin
      winner_o = OWN_DMA;
    end else if (req_i == 2'b11) begin
      winner_o = (last_i == OWN_CPU) ? OWN_DMA : OWN_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the CPU load/store path and a DMA
// engine: grant in IDLE, WAIT_CYCLES of memory enable, then a done pulse.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AW          = 16,
  parameter int unsigned DW          = 16,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int unsigned MAX_BURST   = MAX_BURST_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req_in,
  input  logic          cpu_we_in,
  input  logic [AW-1:0] cpu_addr_in,
  input  logic [DW-1:0] cpu_wdata_in,
  output logic          cpu_gnt_out,
  output logic          cpu_done_out,
  output logic [DW-1:0] cpu_rdata_out,
  input  logic          dma_req_in,
  input  logic          dma_we_in,
  input  logic          dma_lock_in,
  input  logic [AW-1:0] dma_addr_in,
  input  logic [DW-1:0] dma_wdata_in,
  output logic          dma_gnt_out,
  output logic          dma_done_out,
  output logic [DW-1:0] dma_rdata_out,
  output logic          mem_en_out,
  output logic          mem_wen_out,
  output logic [AW-1:0] mem_addr_out,
  output logic [DW-1:0] mem_wdata_out,
  input  logic [DW-1:0] mem_rdata_in
);

  localparam logic [CNT_W-1:0] WaitLast = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MaxBurst = CNT_W'(MAX_BURST);

  arb_state_t       state_q;
  arb_owner_t       last_q, owner_q;
  logic [CNT_W-1:0] burst_q, burst_d, wait_q;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;

  logic       pick_valid, pick_locked, burst_ok;
  arb_owner_t pick_winner;
  logic       grant, in_acc, in_resp;

  assign burst_ok = (burst_q < MaxBurst);

  rr_pick2 u_pick (
    .req_i      ({dma_req_in, cpu_req_in}),
    .last_i     (last_q),
    .lock_i     (dma_lock_in),
    .burst_ok_i (burst_ok),
    .valid_o    (pick_valid),
    .winner_o   (pick_winner),
    .locked_o   (pick_locked)
  );

  // Burst count only moves on a grant; an unlocked-rule DMA win with lock held keeps it.
  always_comb begin
    burst_d = burst_q;
    if (pick_locked) begin
      burst_d = (burst_q == MaxBurst) ? burst_q : burst_q + 1'b1;
    end else if (pick_winner == OWN_CPU || !dma_lock_in) begin
      burst_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= OWN_DMA;
      owner_q <= OWN_CPU;
      burst_q <= '0;
      wait_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            owner_q <= pick_winner;
            we_q    <= (pick_winner == OWN_DMA) ? dma_we_in    : cpu_we_in;
            addr_q  <= (pick_winner == OWN_DMA) ? dma_addr_in  : cpu_addr_in;
            wdata_q <= (pick_winner == OWN_DMA) ? dma_wdata_in : cpu_wdata_in;
            burst_q <= burst_d;
            wait_q  <= '0;
            state_q <= ACC;
          end
        end
        ACC: begin
          if (wait_q == WaitLast) state_q <= RESP;
          else                    wait_q  <= wait_q + 1'b1;
        end
        RESP: begin
          last_q  <= owner_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are forced quiet while reset is asserted.
  assign grant   = !rst && (state_q == IDLE) && pick_valid;
  assign in_acc  = !rst && (state_q == ACC);
  assign in_resp = !rst && (state_q == RESP);

  assign cpu_gnt_out   = grant && (pick_winner == OWN_CPU);
  assign dma_gnt_out   = grant && (pick_winner == OWN_DMA);
  assign cpu_done_out  = in_resp && (owner_q == OWN_CPU);
  assign dma_done_out  = in_resp && (owner_q == OWN_DMA);
  assign cpu_rdata_out = (cpu_done_out && !we_q) ? mem_rdata_in : '0;
  assign dma_rdata_out = (dma_done_out && !we_q) ? mem_rdata_in : '0;

  assign mem_en_out    = in_acc;
  assign mem_wen_out   = in_acc ? ~we_q : 1'b1;
  assign mem_addr_out  = in_acc ? addr_q  : '0;
  assign mem_wdata_out = in_acc ? wdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a cycle-numbered transaction model checks
// every output every cycle, and hand-computed literals pin the scenarios.
module tb_dmem_arbiter;

  localparam int W  = 1;
  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
  logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic        cpu_gnt, cpu_done, dma_gnt, dma_done, mem_en, mem_wen;
  logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;

  logic        c3_req;
  logic [15:0] c3_addr;
  logic        g3, d3, dg3, dd3, en3, wen3;
  logic [15:0] r3, dr3, a3, wd3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(16), .DW(16), .WAIT_CYCLES(W), .MAX_BURST(MB)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req_in(cpu_req), .cpu_we_in(cpu_we), .cpu_addr_in(cpu_addr), .cpu_wdata_in(cpu_wdata),
    .cpu_gnt_out(cpu_gnt), .cpu_done_out(cpu_done), .cpu_rdata_out(cpu_rdata),
    .dma_req_in(dma_req), .dma_we_in(dma_we), .dma_lock_in(dma_lock), .dma_addr_in(dma_addr),
    .dma_wdata_in(dma_wdata), .dma_gnt_out(dma_gnt), .dma_done_out(dma_done), .dma_rdata_out(dma_rdata),
    .mem_en_out(mem_en), .mem_wen_out(mem_wen), .mem_addr_out(mem_addr), .mem_wdata_out(mem_wdata),
    .mem_rdata_in(mem_rdata)
  );

  dmem_arbiter #(.AW(16), .DW(16), .WAIT_CYCLES(3), .MAX_BURST(MB)) u_dut3 (
    .clk(clk), .rst(rst),
    .cpu_req_in(c3_req), .cpu_we_in(1'b0), .cpu_addr_in(c3_addr), .cpu_wdata_in(16'h0),
    .cpu_gnt_out(g3), .cpu_done_out(d3), .cpu_rdata_out(r3),
    .dma_req_in(1'b0), .dma_we_in(1'b0), .dma_lock_in(1'b0), .dma_addr_in(16'h0),
    .dma_wdata_in(16'h0), .dma_gnt_out(dg3), .dma_done_out(dd3), .dma_rdata_out(dr3),
    .mem_en_out(en3), .mem_wen_out(wen3), .mem_addr_out(a3), .mem_wdata_out(wd3),
    .mem_rdata_in(mem_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction model: an access granted in cycle g enables memory in cycles
  // g+1..g+W, completes in g+W+1, and the next grant is possible from g+W+2.
  int          m_cyc = 0;
  int          m_gcyc = -1;
  bit          m_last_dma = 1'b1;
  bit          m_own_dma, m_we;
  logic [15:0] m_addr, m_wdata;
  int          m_burst = 0;

  always @(negedge clk) begin : model
    bit busy, e_en, e_done, e_gc, e_gd, win_dma;
    e_en = 0; e_done = 0; e_gc = 0; e_gd = 0;
    if (rst) begin
      m_gcyc     = -1;
      m_last_dma = 1'b1;
      m_burst    = 0;
    end else begin
      busy   = (m_gcyc >= 0) && (m_cyc <= m_gcyc + W + 1);
      e_en   = busy && (m_cyc > m_gcyc) && (m_cyc <= m_gcyc + W);
      e_done = busy && (m_cyc == m_gcyc + W + 1);
      if (e_done) m_last_dma = m_own_dma;
      if (!busy && (cpu_req || dma_req)) begin
        if (m_last_dma && dma_lock && dma_req && (m_burst < MB || !cpu_req)) begin
          win_dma = 1'b1;
          m_burst = (m_burst < MB) ? m_burst + 1 : MB;
        end else begin
          win_dma = cpu_req ? (dma_req && !m_last_dma) : 1'b1;
          if (!win_dma || !dma_lock) m_burst = 0;
        end
        m_own_dma = win_dma;
        m_we      = win_dma ? dma_we    : cpu_we;
        m_addr    = win_dma ? dma_addr  : cpu_addr;
        m_wdata   = win_dma ? dma_wdata : cpu_wdata;
        m_gcyc    = m_cyc;
        e_gc      = !win_dma;
        e_gd      = win_dma;
      end
    end
    check("m_cpu_gnt",  cpu_gnt,  e_gc);
    check("m_dma_gnt",  dma_gnt,  e_gd);
    check("m_cpu_done", cpu_done, e_done && !m_own_dma);
    check("m_dma_done", dma_done, e_done &&  m_own_dma);
    check("m_cpu_rdata", cpu_rdata, (e_done && !m_own_dma && !m_we) ? mem_rdata : 16'h0);
    check("m_dma_rdata", dma_rdata, (e_done &&  m_own_dma && !m_we) ? mem_rdata : 16'h0);
    check("m_mem_en",    mem_en,    e_en);
    check("m_mem_wen",   mem_wen,   e_en ? !m_we : 1'b1);
    check("m_mem_addr",  mem_addr,  e_en ? m_addr  : 16'h0);
    check("m_mem_wdata", mem_wdata, e_en ? m_wdata : 16'h0);
    m_cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = 0; dma_wdata = 0;
    mem_rdata = 0; c3_req = 0; c3_addr = 0;
    step(); step();
    @(negedge clk);
    check("rst_mem_wen", mem_wen, 1'b1);
    check("rst_mem_en",  mem_en,  1'b0);
    step(); rst = 1'b0;

    // Test 1: CPU read.
    step();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010; mem_rdata = 16'hBEEF;
    @(negedge clk); check("t1_gnt", cpu_gnt, 1'b1);
    step(); cpu_req = 0;
    @(negedge clk); check("t1_en", mem_en, 1'b1); check("t1_wen", mem_wen, 1'b1);
    check("t1_addr", mem_addr, 16'h0010);
    step();
    @(negedge clk); check("t1_done", cpu_done, 1'b1); check("t1_rdata", cpu_rdata, 16'hBEEF);
    step();

    // Test 2: DMA write.
    dma_req = 1; dma_we = 1; dma_addr = 16'h0020; dma_wdata = 16'h1234;
    @(negedge clk); check("t2_gnt", dma_gnt, 1'b1); check("t2_cpu_gnt", cpu_gnt, 1'b0);
    step(); dma_req = 0;
    @(negedge clk); check("t2_wen", mem_wen, 1'b0); check("t2_wdata", mem_wdata, 16'h1234);
    step();
    @(negedge clk); check("t2_done", dma_done, 1'b1); check("t2_rdata", dma_rdata, 16'h0);
    step();

    // Test 3: both requesting, no lock, from reset: CPU, DMA, CPU, DMA.
    rst = 1; step(); rst = 0;
    cpu_req = 1; dma_req = 1; dma_we = 0; cpu_addr = 16'h0100; dma_addr = 16'h0200;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("t3_cpu_gnt", cpu_gnt, (i % 6) == 0);
      check("t3_dma_gnt", dma_gnt, (i % 6) == 3);
      step();
    end

    // Test 4: CPU grant, natural DMA win, 4 locked DMA grants, then CPU.
    dma_req = 0; dma_lock = 0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      check("t4_cpu_gnt", cpu_gnt, (i == 0) || (i == 18));
      check("t4_dma_gnt", dma_gnt, (i >= 3) && (i <= 15) && (i % 3 == 0));
      if (i == 19) check("t4_burst", u_dut.burst_q, 0);
      step();
      if (i == 0)  begin dma_req = 1; dma_lock = 1; end
      if (i == 18) begin cpu_req = 0; dma_req = 0; dma_lock = 0; end
    end

    // Test 6: reset during ACC aborts; CPU wins the following tie.
    cpu_req = 1; cpu_addr = 16'h0030;
    @(negedge clk); check("t6_gnt", cpu_gnt, 1'b1);
    step(); cpu_req = 0; rst = 1;
    step(); rst = 0; cpu_req = 1; dma_req = 1;
    @(negedge clk);
    check("t6_en", mem_en, 1'b0); check("t6_done", cpu_done, 1'b0);
    check("t6_tie_cpu", cpu_gnt, 1'b1); check("t6_tie_dma", dma_gnt, 1'b0);
    step(); cpu_req = 0; dma_req = 0;
    step(); step(); step();

    // Test 5: WAIT_CYCLES=3 instance.
    mem_rdata = 16'h5A5A; c3_req = 1; c3_addr = 16'h0040;
    @(negedge clk); check("t5_gnt", g3, 1'b1);
    step(); c3_req = 0;
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      check("t5_en",    en3, (t <= 3));
      check("t5_done",  d3,  (t == 4));
      check("t5_rdata", r3,  (t == 4) ? 16'h5A5A : 16'h0);
      if (t == 2) check("t5_addr", a3, 16'h0040);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
